// File: rtl/ppm_stream_pkg.sv
// Shared types, ASCII constants and elaboration-time helpers for the PGM (P5) UART streamer.
// The helpers build the header text from the image dimensions.
package ppm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PIXELS,
    DONE
  } state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;

  // Pixel counters are this wide so 9999*9999 cannot wrap.
  localparam int CNT_W = 27;

  function automatic int num_digits(input int v);
    int n;
    int r;
    n = 1;
    r = v;
    while (r >= 10) begin
      r = r / 10;
      n++;
    end
    return n;
  endfunction

  // k-th decimal digit of v, counted from the most significant digit.
  function automatic int digit_at(input int v, input int k);
    int r;
    int shifts;
    r = v;
    shifts = num_digits(v) - 1 - k;
    for (int i = 0; i < shifts; i++) r = r / 10;
    return r % 10;
  endfunction

  function automatic int hdr_len(input int w, input int h);
    return 9 + num_digits(w) + num_digits(h);
  endfunction

  // Byte idx of "P5\n<w> <h>\n255\n".
  function automatic logic [7:0] header_byte(input int idx, input int w, input int h);
    int dw;
    int dh;
    logic [7:0] b;
    dw = num_digits(w);
    dh = num_digits(h);
    if (idx == 0)                b = 8'h50;
    else if (idx == 1)           b = 8'h35;
    else if (idx == 2)           b = ASCII_LF;
    else if (idx < 3 + dw)       b = ASCII_0 + 8'(digit_at(w, idx - 3));
    else if (idx == 3 + dw)      b = ASCII_SP;
    else if (idx < 4 + dw + dh)  b = ASCII_0 + 8'(digit_at(h, idx - 4 - dw));
    else if (idx == 4 + dw + dh) b = ASCII_LF;
    else if (idx == 5 + dw + dh) b = 8'h32;
    else if (idx < 8 + dw + dh)  b = 8'h35;
    else                         b = ASCII_LF;
    return b;
  endfunction

endpackage

// File: rtl/ppm_uart_streamer_uart_tx.sv
// 8N1 serialiser. idle is also high in the last stop-bit cycle, so a new byte
// can be loaded there and follow with no gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       idle
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          last_tick;

  assign last_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign idle      = !active_q || ((bit_q == 4'd9) && last_tick);
  assign txd       = txd_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    active_d = active_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    if (load && idle) begin
      active_d = 1'b1;
      bit_d    = 4'd0;
      cnt_d    = '0;
      shift_d  = {1'b1, data, 1'b0};
      txd_d    = 1'b0;
    end else if (active_q) begin
      if (last_tick) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
          txd_d   = shift_q[1];
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      cnt_q    <= '0;
      shift_q  <= '1;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: rtl/ppm_uart_streamer.sv
// Buffers the grayscale pixel stream in a small FIFO and sends one P5 frame
// (header then pixels) over the UART per start request.
module ppm_uart_streamer
  import ppm_stream_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HDR_LEN      = hdr_len(IMG_W, IMG_H);
  localparam int HDR_W        = $clog2(HDR_LEN);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(IMG_W * IMG_H);

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     fifo_cnt_q, fifo_cnt_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         hdr_rom [HDR_LEN];

  logic       in_frame, fifo_empty, fifo_full, push, pop;
  logic       tx_load, tx_idle;
  logic [7:0] tx_data;

  for (genvar i = 0; i < HDR_LEN; i++) begin : g_hdr
    localparam logic [7:0] HB = header_byte(i, IMG_W, IMG_H);
    assign hdr_rom[i] = HB;
  end

  assign in_frame   = (state_q == HEADER) || (state_q == PIXELS);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign pix_ready  = in_frame && !fifo_full && (acc_cnt_q < TOTAL);
  assign push       = pix_valid && pix_ready;

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    acc_cnt_d    = acc_cnt_q;
    sent_cnt_d   = sent_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    pop          = 1'b0;
    tx_load      = 1'b0;
    tx_data      = hdr_rom[hdr_idx_q];

    if (push) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    // Beats refused only because the frame already has all its pixels are not an error.
    if (in_frame && pix_valid && !pix_ready && (acc_cnt_q < TOTAL)) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HEADER;
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          acc_cnt_d  = '0;
          sent_cnt_d = '0;
          hdr_idx_d  = '0;
        end
      end
      HEADER: begin
        if (tx_idle) begin
          tx_load = 1'b1;
          if (hdr_idx_q == HDR_W'(HDR_LEN - 1)) state_d = PIXELS;
          else hdr_idx_d = hdr_idx_q + HDR_W'(1);
        end
      end
      PIXELS: begin
        if (sent_cnt_q == TOTAL) begin
          if (tx_idle) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end
        end else if (tx_idle && !fifo_empty) begin
          tx_load    = 1'b1;
          tx_data    = mem_q[rd_ptr_q];
          pop        = 1'b1;
          sent_cnt_d = sent_cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (PTR_W + 1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (PTR_W + 1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hdr_idx_q    <= '0;
      acc_cnt_q    <= '0;
      sent_cnt_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      sent_cnt_q   <= sent_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .load (tx_load),
    .data (tx_data),
    .txd  (uart_txd),
    .idle (tx_idle)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ppm_uart_streamer.sv
// Scoreboard bench: expected UART bytes are queued as header/pixels are issued and
// a UART-decoding monitor pops and compares them.
`timescale 1ns/1ps
module tb_ppm_uart_streamer;

  localparam int BAUD    = 115200;
  localparam int CPB     = 4;
  localparam int CLK_HZ  = BAUD * CPB;
  localparam int AW      = 2;
  localparam int AH      = 2;
  localparam int A_TOTAL = AW * AH;
  localparam int BW      = 3;
  localparam int BH      = 3;
  localparam int B_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_start, a_pix_valid, a_pix_ready, a_txd, a_busy, a_frame_done, a_overflow;
  logic [7:0] a_pix_data;
  logic       b_reset, b_start, b_pix_valid, b_pix_ready, b_txd, b_busy, b_frame_done, b_overflow;
  logic [7:0] b_pix_data;

  ppm_uart_streamer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_W(AW), .IMG_H(AH), .FIFO_DEPTH(16)
  ) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .pix_data(a_pix_data),
    .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .uart_txd(a_txd),
    .busy(a_busy), .frame_done(a_frame_done), .overflow(a_overflow)
  );

  ppm_uart_streamer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMG_W(BW), .IMG_H(BH), .FIFO_DEPTH(B_DEPTH)
  ) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .pix_data(b_pix_data),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .uart_txd(b_txd),
    .busy(b_busy), .frame_done(b_frame_done), .overflow(b_overflow)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic [7:0] px[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference header text from the image dimensions.
  task automatic push_header(input int w, input int h);
    string s;
    s = $sformatf("P5\n%0d %0d\n255\n", w, h);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Decodes dut_a's serial line, sampling mid-bit, and checks against the scoreboard.
  initial begin : uart_monitor
    logic [7:0] rx;
    logic       sb_bit;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (a_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        sb_bit = a_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = a_txd;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = a_txd;
        if (mon_en) begin
          check("start_bit", sb_bit, 1'b0);
          check("stop_bit", stop_bit, 1'b1);
          check("byte_was_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("uart_byte", rx, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start_a();
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // One dut_a frame: offers n_offer pixels from px[], with random gaps up to max_gap.
  task automatic run_frame_a(input int n_offer, input int max_gap, input bit timing, input bit extra_start);
    int         first_sb, fd_k, fd_cnt, hs, offered, gap, post;
    bit         xfer, prev_busy, ready_late, ovf_seen;
    logic [39:0] bits_got, bits_exp;
    logic [7:0] first_byte;
    first_sb = -1; fd_k = -1; fd_cnt = 0; hs = 0; offered = 0; gap = 0; post = -1;
    prev_busy = 1'b0; ready_late = 1'b0; ovf_seen = 1'b0; bits_got = '0;
    @(posedge clk); #1;
    a_start = 1'b1;
    push_header(AW, AH);
    @(posedge clk); #1;
    a_start     = 1'b0;
    a_pix_valid = (n_offer > 0);
    a_pix_data  = px[0];
    for (int k = 0; k < 4000 && post != 0; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_after_start", a_busy, 1'b1);
      if (first_sb < 0 && a_txd == 1'b0) first_sb = k;
      if (first_sb >= 0 && k - first_sb < 40) bits_got[k - first_sb] = a_txd;
      if (a_frame_done) begin
        fd_cnt++;
        if (fd_k < 0) begin
          fd_k = k;
          check("busy_low_with_done", a_busy, 1'b0);
          check("busy_high_before_done", prev_busy, 1'b1);
          post = 6;
        end
      end
      prev_busy = a_busy;
      if (hs >= A_TOTAL && a_pix_ready) ready_late = 1'b1;
      if (a_overflow) ovf_seen = 1'b1;
      xfer = a_pix_valid && a_pix_ready;
      if (post > 0) post--;
      @(posedge clk); #1;
      if (extra_start) a_start = (k == 120);
      if (xfer) begin
        exp_q.push_back(a_pix_data);
        hs++;
        offered++;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      end
      if (gap > 0) begin
        a_pix_valid = 1'b0;
        gap--;
      end else if (offered < n_offer) begin
        a_pix_valid = 1'b1;
        a_pix_data  = px[offered];
      end else begin
        a_pix_valid = 1'b0;
      end
    end
    a_pix_valid = 1'b0;
    a_start     = 1'b0;
    check("frame_done_seen", fd_k >= 0, 1'b1);
    check("frame_done_pulses", fd_cnt, 1);
    check("handshakes", hs, A_TOTAL);
    check("no_ready_after_total", ready_late, 1'b0);
    check("no_overflow", ovf_seen, 1'b0);
    if (timing) begin
      check("done_latency", fd_k - first_sb, 15 * 10 * CPB);
      first_byte = 8'h50;
      for (int j = 0; j < 40; j++) begin
        if (j / CPB == 0)      bits_exp[j] = 1'b0;
        else if (j / CPB == 9) bits_exp[j] = 1'b1;
        else                   bits_exp[j] = first_byte[j / CPB - 1];
      end
      check("first_byte_bits", bits_got, bits_exp);
    end
    repeat (60) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : main
    int hs, k0, fd_seen, n;
    a_reset = 1'b1; a_start = 1'b0; a_pix_valid = 1'b0; a_pix_data = '0;
    b_reset = 1'b1; b_start = 1'b0; b_pix_valid = 1'b0; b_pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Reset values, and pix_valid in IDLE is ignored.
    @(negedge clk);
    check("rst_txd", a_txd, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_pix_ready, 1'b0);
    check("rst_overflow", a_overflow, 1'b0);
    check("rst_done", a_frame_done, 1'b0);
    check("rst_b_txd", b_txd, 1'b1);
    a_pix_valid = 1'b1;
    repeat (5) @(negedge clk);
    a_pix_valid = 1'b0;
    @(negedge clk);
    check("idle_valid_no_overflow", a_overflow, 1'b0);
    check("idle_ready_low", a_pix_ready, 1'b0);
    mon_en = 1'b1;

    // Fixed small frame with bit-timing and latency checks.
    px[0] = 8'h00; px[1] = 8'hFF; px[2] = 8'h80; px[3] = 8'h7F;
    run_frame_a(4, 0, 1'b1, 1'b0);

    // Excess pixels offered with valid held high.
    for (int i = 0; i < 8; i++) px[i] = 8'($urandom);
    run_frame_a(6, 0, 1'b0, 1'b0);

    // Random pixels with random valid gaps.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) px[i] = 8'($urandom);
      run_frame_a(4, 3, 1'b0, 1'b0);
    end

    // Backpressure on the 4-deep FIFO during the header.
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start     = 1'b0;
    b_pix_valid = 1'b1;
    b_pix_data  = 8'($urandom);
    hs = 0; k0 = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (b_pix_valid && b_pix_ready) hs++;
      else if (k0 < 0) begin
        k0 = k;
        check("b_overflow_not_yet", b_overflow, 1'b0);
      end else if (k == k0 + 1) begin
        check("b_overflow_set", b_overflow, 1'b1);
      end
      @(posedge clk); #1;
      b_pix_data = 8'($urandom);
    end
    check("b_accepted_during_header", hs, B_DEPTH);
    check("b_ready_low_when_full", b_pix_ready, 1'b0);
    fd_seen = 0;
    for (int k = 0; k < 3000 && fd_seen == 0; k++) begin
      @(negedge clk);
      if (b_frame_done) begin
        fd_seen = 1;
        check("b_overflow_sticky", b_overflow, 1'b1);
      end
    end
    check("b_frame_done_seen", fd_seen, 1);
    b_pix_valid = 1'b0;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    @(negedge clk);
    check("b_restart_clears_overflow", b_overflow, 1'b0);
    check("b_restart_busy", b_busy, 1'b1);
    #2;
    b_reset = 1'b1;
    #2;
    b_reset = 1'b0;

    // Reset in the middle of a pixel byte, then a clean retransmission.
    mon_en = 1'b0;
    pulse_start_a();
    a_pix_valid = 1'b1;
    a_pix_data  = 8'($urandom);
    repeat (450) @(negedge clk);
    n = 0;
    while (a_txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("txd_low_before_reset", a_txd, 1'b0);
    check("busy_before_reset", a_busy, 1'b1);
    #2;
    a_reset = 1'b1;
    #1;
    check("reset_txd_immediate", a_txd, 1'b1);
    check("reset_busy_immediate", a_busy, 1'b0);
    check("reset_ready_immediate", a_pix_ready, 1'b0);
    @(posedge clk); #1;
    a_reset     = 1'b0;
    a_pix_valid = 1'b0;
    repeat (60) @(negedge clk);
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) px[i] = 8'($urandom);
    run_frame_a(4, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
